// File: rtl/bcd_seq_adder_if.sv
// bcd_seq_adder_if: request/result bundle between a requester and the serial BCD adder.
interface bcd_seq_adder_if #(parameter int DIGITS = 2);
    logic                  start;
    logic                  op;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;
    logic                  busy;
    logic                  done;
    logic [7*DIGITS-1:0]   seg_a;
    logic [7*DIGITS-1:0]   seg_b;
    logic [7*DIGITS-1:0]   seg_s;
    modport master (output start, op, a, b,
                    input  sum, cout, err, busy, done, seg_a, seg_b, seg_s);
    modport slave  (input  start, op, a, b,
                    output sum, cout, err, busy, done, seg_a, seg_b, seg_s);
endinterface

// File: rtl/bcd_seq_adder.sv
// bcd_seq_adder: digit-serial BCD add/subtract, one digit per clock, with 7-segment views of operands and result.
module bcd_seq_adder #(
    parameter int DIGITS         = 2,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input logic            CLOCK_50,
    input logic            RESET,
    bcd_seq_adder_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t              state, state_n;
    logic [4*DIGITS-1:0] ra, rb, sum_r;
    logic                rop, carry, cout_r, err_r;
    logic [IW-1:0]       idx;
    logic                bad, last, c_n;
    logic [3:0]          ai, bi, dig;
    logic [4:0]          t_add, t_sub;
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0001100;
            default: s = 7'b1111111;
        endcase
        return SEG_ACTIVE_LOW ? s : ~s;
    endfunction
    always_ff @(posedge CLOCK_50 or posedge RESET)
        if (RESET) state <= IDLE;
        else       state <= state_n;
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | (bus.a[4*i +: 4] > 4'd9) | (bus.b[4*i +: 4] > 4'd9);
        last    = idx == IW'(DIGITS - 1);
        state_n = state;
        if (state == IDLE && bus.start) state_n = bad ? DONE : ADD;
        else if (state == ADD && last)  state_n = DONE;
        else if (state == DONE)         state_n = IDLE;
    end
    // Subtraction goes negative in 5-bit two's complement; bit 4 is the borrow.
    always_comb begin
        ai    = ra[4*idx +: 4];
        bi    = rb[4*idx +: 4];
        t_add = {1'b0, ai} + {1'b0, bi} + {4'b0, carry};
        t_sub = {1'b0, ai} - {1'b0, bi} - {4'b0, carry};
        c_n   = rop ? t_sub[4] : (t_add > 5'd9);
        dig   = rop ? (t_sub[4] ? 4'(t_sub + 5'd10) : t_sub[3:0])
                    : (c_n ? 4'(t_add - 5'd10) : t_add[3:0]);
    end
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            ra     <= '0;
            rb     <= '0;
            rop    <= 1'b0;
            sum_r  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            ra    <= bus.a;
            rb    <= bus.b;
            idx   <= '0;
            carry <= 1'b0;
            err_r <= bad;
            if (bad) begin
                sum_r  <= '0;
                cout_r <= 1'b0;
            end else begin
                rop <= bus.op;
            end
        end else if (state == ADD) begin
            sum_r[4*idx +: 4] <= dig;
            carry             <= c_n;
            idx               <= idx + 1'b1;
            if (last) cout_r <= c_n;
        end
    end
    always_comb begin
        bus.seg_a = '0;
        bus.seg_b = '0;
        bus.seg_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bus.seg_a[7*i +: 7] = seg7(ra[4*i +: 4]);
            bus.seg_b[7*i +: 7] = seg7(rb[4*i +: 4]);
            bus.seg_s[7*i +: 7] = seg7(sum_r[4*i +: 4]);
        end
    end
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.err  = err_r;
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
endmodule

// File: tb/tb_bcd_seq_adder.sv
// tb_bcd_seq_adder: directed and random checks of the serial BCD adder against a decimal arithmetic model.
module tb_bcd_seq_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};
    always #10 clk = ~clk;
    bcd_seq_adder_if #(.DIGITS(2)) bus ();
    bcd_seq_adder #(.DIGITS(2), .SEG_ACTIVE_LOW(1)) dut (.CLOCK_50(clk), .RESET(rst), .bus(bus));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [6:0] seg1(input logic [3:0] d);
        return (d > 4'd9) ? 7'h7f : seg_tab[d];
    endfunction
    function automatic logic [13:0] seg2(input logic [7:0] v);
        return {seg1(v[7:4]), seg1(v[3:0])};
    endfunction
    function automatic int to_int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction
    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction
    // Decimal reference: plain integer add/sub modulo 100, carry/borrow from the range overflow.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic op, input string tag);
        int r, lat;
        logic bad;
        logic [7:0] exp_sum;
        logic exp_cout;
        bad = (a[7:4] > 9) || (a[3:0] > 9) || (b[7:4] > 9) || (b[3:0] > 9);
        r = op ? to_int(a) - to_int(b) : to_int(a) + to_int(b);
        exp_cout = bad ? 1'b0 : (op ? (r < 0) : (r > 99));
        exp_sum  = bad ? 8'h00 : to_bcd((r + 100) % 100);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.op = op; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), bad ? 32'd0 : 32'd2);
        check({tag, " sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, " cout"}, 32'(bus.cout), 32'(exp_cout));
        check({tag, " err"}, 32'(bus.err), 32'(bad));
        check({tag, " busy_done"}, 32'(bus.busy), 32'd1);
        check({tag, " seg_s"}, 32'(bus.seg_s), 32'(seg2(exp_sum)));
        check({tag, " seg_a"}, 32'(bus.seg_a), 32'(seg2(a)));
        check({tag, " seg_b"}, 32'(bus.seg_b), 32'(seg2(b)));
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
        bus.a = 8'h77; bus.b = 8'h33;
        #1;
        check({tag, " hold_sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, " hold_seg_a"}, 32'(bus.seg_a), 32'(seg2(a)));
    endtask
    initial begin
        int ndone;
        logic [7:0] ra, rb;
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset sum", 32'(bus.sum), 32'd0);
        check("reset cout_err", 32'({bus.cout, bus.err}), 32'd0);
        check("reset seg_s", 32'(bus.seg_s), 32'({2{7'b0000001}}));
        check("reset seg_a", 32'(bus.seg_a), 32'({2{7'b0000001}}));
        @(negedge clk); rst = 1'b0;
        do_op(8'h45, 8'h37, 1'b0, "add45_37");
        do_op(8'h99, 8'h01, 1'b0, "add99_01");
        do_op(8'h37, 8'h45, 1'b1, "sub37_45");
        do_op(8'h45, 8'h37, 1'b1, "sub45_37");
        do_op(8'h1A, 8'h05, 1'b0, "err1A");
        do_op(8'h00, 8'h01, 1'b1, "sub00_01");
        // A second start while adding must be dropped.
        @(negedge clk);
        bus.a = 8'h12; bus.b = 8'h34; bus.op = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.a = 8'h99; bus.b = 8'h99; bus.op = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("restart done_count", 32'(ndone), 32'd1);
        check("restart sum", 32'(bus.sum), 32'h46);
        check("restart seg_a", 32'(bus.seg_a), 32'(seg2(8'h12)));
        // Reset during ADD aborts without a done pulse.
        @(negedge clk);
        bus.a = 8'h11; bus.b = 8'h22; bus.op = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort sum", 32'(bus.sum), 32'd0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("abort no_done", 32'(ndone), 32'd0);
        @(negedge clk); rst = 1'b0;
        do_op(8'h11, 8'h22, 1'b0, "after_abort");
        for (int i = 0; i < 40; i++) begin
            ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 7) == 0) ra[3:0] = 4'($urandom_range(10, 15));
            do_op(ra, rb, 1'($urandom_range(0, 1)), "rand");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
